// File: rtl/lsu.sv
// Load/store unit: single outstanding request towards data memory.
// Formats load data and reports misaligned, illegal and timed-out accesses.
module lsu #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ip_req_valid,
    output logic        op_req_ready,
    input  logic        ip_req_wr,
    input  logic [2:0]  ip_req_funct3,
    input  logic [31:0] ip_req_addr,
    input  logic [31:0] ip_req_wdata,
    output logic        op_resp_valid,
    output logic [31:0] op_resp_rdata,
    output logic [1:0]  op_resp_err,
    output logic [31:0] op_data_addr,
    output logic        op_data_wr,
    output logic [3:0]  op_data_mask,
    output logic [31:0] op_data_to_dmem,
    output logic        op_data_rd,
    input  logic        ip_data_valid,
    input  logic [31:0] ip_data_from_dmem
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          wr_q, wr_d;
    logic [2:0]    f3_q, f3_d;
    logic [1:0]    err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          req_illegal;
    logic          req_misal;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_fmt;

    // Request classification on the raw request inputs
    always_comb begin
        if (ip_req_wr) begin
            req_illegal = ip_req_funct3[2] || (ip_req_funct3[1:0] == 2'b11);
        end else begin
            req_illegal = (ip_req_funct3[1:0] == 2'b11) ||
                          (ip_req_funct3 == 3'b110);
        end
        req_misal = ((ip_req_funct3[1:0] == 2'b01) && ip_req_addr[0]) ||
                    ((ip_req_funct3[1:0] == 2'b10) &&
                     (ip_req_addr[1:0] != 2'b00));
    end

    always_comb begin
        ld_byte = ip_data_from_dmem[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? ip_data_from_dmem[31:16]
                            : ip_data_from_dmem[15:0];
        case (f3_q)
            3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_fmt = {24'h0, ld_byte};
            3'b101:  ld_fmt = {16'h0, ld_half};
            default: ld_fmt = ip_data_from_dmem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wr_q    <= 1'b0;
            f3_q    <= '0;
            err_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wr_q    <= wr_d;
            f3_q    <= f3_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        wr_d    = wr_q;
        f3_d    = f3_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (ip_req_valid) begin
                    addr_d  = ip_req_addr;
                    wdata_d = ip_req_wdata;
                    wr_d    = ip_req_wr;
                    f3_d    = ip_req_funct3;
                    cnt_d   = '0;
                    if (req_illegal) begin
                        state_d = RESP;
                        err_d   = 2'b11;
                        rdata_d = '0;
                    end else if (req_misal) begin
                        state_d = RESP;
                        err_d   = 2'b01;
                        rdata_d = '0;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (wr_q) begin
                    state_d = RESP;
                    err_d   = 2'b00;
                    rdata_d = '0;
                end else if (ip_data_valid) begin
                    state_d = RESP;
                    err_d   = 2'b00;
                    rdata_d = ld_fmt;
                end else begin
                    if (cnt_q != CW'(TIMEOUT_CYCLES)) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    // This cycle is the last one the load may wait
                    if (cnt_q >= CW'(TIMEOUT_CYCLES - 1)) begin
                        state_d = RESP;
                        err_d   = 2'b10;
                        rdata_d = '0;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        op_req_ready    = (state_q == IDLE);
        op_resp_valid   = (state_q == RESP);
        op_resp_rdata   = rdata_q;
        op_resp_err     = err_q;
        op_data_addr    = '0;
        op_data_wr      = 1'b0;
        op_data_rd      = 1'b0;
        op_data_mask    = '0;
        op_data_to_dmem = '0;
        if (state_q == ACCESS) begin
            op_data_addr = {addr_q[31:2], 2'b00};
            op_data_wr   = wr_q;
            op_data_rd   = !wr_q;
            case (f3_q[1:0])
                2'b00: begin
                    op_data_mask    = 4'b0001 << addr_q[1:0];
                    op_data_to_dmem = {4{wdata_q[7:0]}};
                end
                2'b01: begin
                    op_data_mask    = 4'b0011 << addr_q[1:0];
                    op_data_to_dmem = {2{wdata_q[15:0]}};
                end
                default: begin
                    op_data_mask    = 4'b1111;
                    op_data_to_dmem = wdata_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed vector table, reset corner case and randomized
// requests checked against a byte-lane level reference model.
module tb_lsu;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ip_req_valid;
    logic        op_req_ready;
    logic        ip_req_wr;
    logic [2:0]  ip_req_funct3;
    logic [31:0] ip_req_addr;
    logic [31:0] ip_req_wdata;
    logic        op_resp_valid;
    logic [31:0] op_resp_rdata;
    logic [1:0]  op_resp_err;
    logic [31:0] op_data_addr;
    logic        op_data_wr;
    logic [3:0]  op_data_mask;
    logic [31:0] op_data_to_dmem;
    logic        op_data_rd;
    logic        ip_data_valid;
    logic [31:0] ip_data_from_dmem;

    int nchk = 0;
    int nerr = 0;

    lsu #(.TIMEOUT_CYCLES(T)) dut (
        .clk               (clk),
        .reset             (reset),
        .ip_req_valid      (ip_req_valid),
        .op_req_ready      (op_req_ready),
        .ip_req_wr         (ip_req_wr),
        .ip_req_funct3     (ip_req_funct3),
        .ip_req_addr       (ip_req_addr),
        .ip_req_wdata      (ip_req_wdata),
        .op_resp_valid     (op_resp_valid),
        .op_resp_rdata     (op_resp_rdata),
        .op_resp_err       (op_resp_err),
        .op_data_addr      (op_data_addr),
        .op_data_wr        (op_data_wr),
        .op_data_mask      (op_data_mask),
        .op_data_to_dmem   (op_data_to_dmem),
        .op_data_rd        (op_data_rd),
        .ip_data_valid     (ip_data_valid),
        .ip_data_from_dmem (ip_data_from_dmem)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          lat;
        int          rdn;
        int          wrn;
        logic [1:0]  err;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        bit          idle_bad;
        bit          unstable;
    } obs_t;

    typedef struct {
        bit        wr;
        bit [2:0]  f3;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [31:0] mem;
        int        dly;
        bit [1:0]  err;
        bit [31:0] rdata;
        bit [3:0]  mask;
        bit [31:0] wd;
        int        lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: lane-wise view of the access, timing from the protocol
    function automatic obs_t model(input bit wr, input bit [2:0] f3,
                                   input bit [31:0] a, input bit [31:0] wd,
                                   input bit [31:0] mem, input int dly);
        obs_t e;
        int size;
        int off;
        bit sgn;
        bit ill;
        logic [31:0] w;
        e = '{0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0};
        size = 4;
        sgn = 1'b0;
        ill = 1'b0;
        case (f3)
            3'd0: begin size = 1; sgn = 1'b1; end
            3'd1: begin size = 2; sgn = 1'b1; end
            3'd2: size = 4;
            3'd4: size = 1;
            3'd5: size = 2;
            default: ill = 1'b1;
        endcase
        if (wr && f3 > 3'd2) ill = 1'b1;
        off = int'(a % 4);
        if (ill) begin
            e.err = 2'b11; e.lat = 1;
        end else if (a % size != 0) begin
            e.err = 2'b01; e.lat = 1;
        end else begin
            e.addr = a - off;
            for (int i = 0; i < 4; i++) begin
                if (i >= off && i < off + size) e.mask[i] = 1'b1;
                e.data[8*i +: 8] = wd[8*(i % size) +: 8];
            end
            if (wr) begin
                e.lat = 2; e.wrn = 1;
            end else if (dly < T) begin
                e.rdn = dly + 1;
                e.lat = dly + 2;
                w = mem >> (8 * off);
                if (size == 1) w = sgn ? {{24{w[7]}}, w[7:0]} : {24'h0, w[7:0]};
                if (size == 2) w = sgn ? {{16{w[15]}}, w[15:0]} : {16'h0, w[15:0]};
                e.rdata = w;
            end else begin
                e.err = 2'b10; e.rdn = T; e.lat = T + 1;
            end
        end
        return e;
    endfunction

    task automatic run_req(input bit wr, input bit [2:0] f3,
                           input bit [31:0] a, input bit [31:0] wd,
                           input bit [31:0] mem, input int dly,
                           output obs_t o);
        bit first;
        o = '{0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0};
        first = 1'b1;
        @(negedge clk);
        chk("ready_before_req", op_req_ready, 1);
        ip_req_valid  = 1'b1;
        ip_req_wr     = wr;
        ip_req_funct3 = f3;
        ip_req_addr   = a;
        ip_req_wdata  = wd;
        @(posedge clk); #1;
        ip_req_valid  = 1'b0;
        ip_req_wr     = 1'($urandom);
        ip_req_funct3 = 3'($urandom);
        ip_req_addr   = $urandom;
        ip_req_wdata  = $urandom;
        for (int c = 1; c <= 40; c++) begin
            if (op_data_rd) begin
                ip_data_valid     = (o.rdn == dly);
                ip_data_from_dmem = ip_data_valid ? mem : $urandom;
            end else begin
                ip_data_valid     = 1'($urandom);
                ip_data_from_dmem = $urandom;
            end
            @(negedge clk);
            if (op_data_rd || op_data_wr) begin
                if (first) begin
                    o.addr = op_data_addr;
                    o.mask = op_data_mask;
                    o.data = op_data_to_dmem;
                    first  = 1'b0;
                end else if (o.addr !== op_data_addr || o.mask !== op_data_mask) begin
                    o.unstable = 1'b1;
                end
            end else if (op_data_addr != 0 || op_data_mask != 0 ||
                         op_data_to_dmem != 0) begin
                o.idle_bad = 1'b1;
            end
            if (op_data_rd) o.rdn++;
            if (op_data_wr) o.wrn++;
            if (op_resp_valid) begin
                o.lat   = c;
                o.err   = op_resp_err;
                o.rdata = op_resp_rdata;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        ip_data_valid = 1'b0;
        @(negedge clk);
        chk("resp_one_pulse", op_resp_valid, 0);
        chk("ready_after_resp", op_req_ready, 1);
        chk("err_held", op_resp_err, o.err);
        chk("rdata_held", op_resp_rdata, o.rdata);
    endtask

    task automatic cmp(input string tag, input obs_t o, input obs_t e,
                       input bit wr);
        chk({tag, "_lat"}, o.lat, e.lat);
        chk({tag, "_err"}, o.err, e.err);
        chk({tag, "_rdata"}, o.rdata, e.rdata);
        chk({tag, "_rdn"}, o.rdn, e.rdn);
        chk({tag, "_wrn"}, o.wrn, e.wrn);
        chk({tag, "_mask"}, o.mask, e.mask);
        chk({tag, "_addr"}, o.addr, e.addr);
        if (wr) chk({tag, "_wdata"}, o.data, e.data);
        chk({tag, "_idle_outs"}, o.idle_bad, 0);
        chk({tag, "_stable"}, o.unstable, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t vecs[12];
        obs_t o;
        obs_t e;
        bit   wr;
        bit [2:0] f3;
        bit [31:0] a;
        bit [31:0] wd;
        bit [31:0] mem;
        int dly;
        int bad;

        vecs[0]  = '{1'b1, 3'b000, 32'h103, 32'hA5, 32'h0, 0,
                     2'b00, 32'h0, 4'b1000, 32'hA5A5A5A5, 2};
        vecs[1]  = '{1'b0, 3'b000, 32'h202, 32'h0, 32'h12F45678, 0,
                     2'b00, 32'hFFFFFFF4, 4'b0100, 32'h0, 2};
        vecs[2]  = '{1'b0, 3'b100, 32'h202, 32'h0, 32'h12F45678, 0,
                     2'b00, 32'h000000F4, 4'b0100, 32'h0, 2};
        vecs[3]  = '{1'b0, 3'b101, 32'h202, 32'h0, 32'h12F45678, 0,
                     2'b00, 32'h000012F4, 4'b1100, 32'h0, 2};
        vecs[4]  = '{1'b0, 3'b010, 32'h006, 32'h0, 32'h0, 0,
                     2'b01, 32'h0, 4'b0000, 32'h0, 1};
        vecs[5]  = '{1'b1, 3'b001, 32'h001, 32'h1234, 32'h0, 0,
                     2'b01, 32'h0, 4'b0000, 32'h0, 1};
        vecs[6]  = '{1'b0, 3'b010, 32'h040, 32'h0, 32'h0, 99,
                     2'b10, 32'h0, 4'b1111, 32'h0, 5};
        vecs[7]  = '{1'b0, 3'b010, 32'h040, 32'h0, 32'hDEADBEEF, 2,
                     2'b00, 32'hDEADBEEF, 4'b1111, 32'h0, 4};
        vecs[8]  = '{1'b0, 3'b011, 32'h010, 32'h0, 32'h0, 0,
                     2'b11, 32'h0, 4'b0000, 32'h0, 1};
        vecs[9]  = '{1'b1, 3'b100, 32'h010, 32'h55, 32'h0, 0,
                     2'b11, 32'h0, 4'b0000, 32'h0, 1};
        vecs[10] = '{1'b0, 3'b001, 32'h002, 32'h0, 32'h80017FFF, 1,
                     2'b00, 32'hFFFF8001, 4'b1100, 32'h0, 3};
        vecs[11] = '{1'b1, 3'b001, 32'h012, 32'hCAFE, 32'h0, 0,
                     2'b00, 32'h0, 4'b1100, 32'hCAFECAFE, 2};

        reset = 1'b1;
        ip_req_valid = 1'b0;
        ip_req_wr = 1'b0;
        ip_req_funct3 = '0;
        ip_req_addr = '0;
        ip_req_wdata = '0;
        ip_data_valid = 1'b0;
        ip_data_from_dmem = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", op_req_ready, 1);
        chk("rst_resp_valid", op_resp_valid, 0);
        chk("rst_rd", op_data_rd, 0);
        chk("rst_wr", op_data_wr, 0);
        chk("rst_mask", op_data_mask, 0);
        chk("rst_rdata", op_resp_rdata, 0);
        chk("rst_err", op_resp_err, 0);

        for (int i = 0; i < 12; i++) begin
            run_req(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                    vecs[i].mem, vecs[i].dly, o);
            chk($sformatf("vec%0d_lat", i), o.lat, vecs[i].lat);
            chk($sformatf("vec%0d_err", i), o.err, vecs[i].err);
            chk($sformatf("vec%0d_rdata", i), o.rdata, vecs[i].rdata);
            chk($sformatf("vec%0d_mask", i), o.mask, vecs[i].mask);
            chk($sformatf("vec%0d_wrn", i), o.wrn,
                (vecs[i].wr && vecs[i].err == 2'b00) ? 1 : 0);
            chk($sformatf("vec%0d_rdn", i), o.rdn,
                (!vecs[i].wr && vecs[i].lat > 1) ? vecs[i].lat - 1 : 0);
            if (vecs[i].lat > 1)
                chk($sformatf("vec%0d_addr", i), o.addr,
                    {vecs[i].addr[31:2], 2'b00});
            if (vecs[i].wr && vecs[i].err == 2'b00)
                chk($sformatf("vec%0d_wdata", i), o.data, vecs[i].wd);
        end

        // Reset in the middle of a stalled load
        @(negedge clk);
        ip_req_valid  = 1'b1;
        ip_req_wr     = 1'b0;
        ip_req_funct3 = 3'b010;
        ip_req_addr   = 32'h40;
        ip_req_wdata  = 32'h0;
        ip_data_valid = 1'b0;
        @(posedge clk); #1;
        ip_req_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_rd_before", op_data_rd, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready", op_req_ready, 1);
        chk("mid_rst_rd", op_data_rd, 0);
        chk("mid_rst_resp", op_resp_valid, 0);
        chk("mid_rst_err", op_resp_err, 0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (op_resp_valid || op_data_rd || !op_req_ready) bad++;
        end
        chk("mid_rst_quiet", bad, 0);
        e = model(1'b1, 3'b010, 32'h80, 32'h01020304, 32'h0, 0);
        run_req(1'b1, 3'b010, 32'h80, 32'h01020304, 32'h0, 0, o);
        cmp("post_rst_sw", o, e, 1'b1);

        for (int n = 0; n < 60; n++) begin
            wr  = 1'($urandom);
            f3  = 3'($urandom);
            a   = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = (f3[1:0] == 2'b10) ? 2'b00 :
                                                     (f3[1:0] == 2'b01) ? {a[1], 1'b0} : a[1:0];
            wd  = $urandom;
            mem = $urandom;
            dly = $urandom_range(0, T + 1);
            e = model(wr, f3, a, wd, mem, dly);
            run_req(wr, f3, a, wd, mem, dly, o);
            cmp($sformatf("rnd%0d", n), o, e, wr);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
